// File: rtl/uart_word_tx.sv
// Serializes 32-bit words as four back-to-back 8N1 frames, MSB byte first.
// All outputs are flops fed from the next-state decode so the line never glitches.
module uart_word_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit_idx;
    logic [1:0]          r_byte_idx;
    logic [WORD_W-1:0]   r_word;
    logic [BYTE_W-1:0]   r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                r_ready;
    logic                r_done;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [1:0]          w_byte_nxt;
    logic [WORD_W-1:0]   w_word_nxt;
    logic [BYTE_W-1:0]   w_shift_nxt;
    logic [BYTE_W-1:0]   w_next_byte;
    logic                w_tx_nxt;
    logic                w_done_nxt;
    logic                w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    // Byte that follows the one currently in the shift register.
    always_comb begin
        w_next_byte = r_word[7:0];
        case (r_byte_idx)
            2'd0:    w_next_byte = r_word[23:16];
            2'd1:    w_next_byte = r_word[15:8];
            default: w_next_byte = r_word[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_word     <= w_word_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_ready    <= (w_state_nxt == S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_word_nxt  = r_word;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (data_valid && r_ready) begin
                    w_word_nxt  = data_in;
                    w_shift_nxt = data_in[31:24];
                    w_byte_nxt  = 2'd0;
                    w_bit_nxt   = 3'd0;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_byte_idx != 2'd3) begin
                        w_byte_nxt  = r_byte_idx + 2'd1;
                        w_shift_nxt = w_next_byte;
                        w_state_nxt = S_START;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level is registered from the state being entered.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign uart_tx    = r_tx;
    assign busy       = r_busy;
    assign data_ready = r_ready;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: CLKS_PER_BIT=4 and CLKS_PER_BIT=2 instances
// checked cycle by cycle against a frame model built from the word.
module tb_uart_word_tx;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_in;
    logic        data_valid;
    bit          sel;

    logic valid1, ready1, tx1, busy1, done1;
    logic valid2, ready2, tx2, busy2, done2;
    logic obs_tx, obs_busy, obs_ready, obs_done;

    int n_err;
    int n_checks;

    assign valid1 = data_valid && !sel;
    assign valid2 = data_valid && sel;

    assign obs_tx    = sel ? tx2    : tx1;
    assign obs_busy  = sel ? busy2  : busy1;
    assign obs_ready = sel ? ready2 : ready1;
    assign obs_done  = sel ? done2  : done1;

    uart_word_tx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (valid1),
        .data_ready (ready1),
        .uart_tx    (tx1),
        .busy       (busy1),
        .tx_done    (done1)
    );

    uart_word_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (valid2),
        .data_ready (ready2),
        .uart_tx    (tx2),
        .busy       (busy2),
        .tx_done    (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the selected DUT idle; returns after the
    // negedge of the tx_done cycle. seen holds the line, first bit at index 0.
    task automatic send_word(input logic [31:0] w, input bit use2, input bit hold,
                             input bit toggle, output logic [39:0] seen);
        int cpb;
        int bad_line;
        int bad_ctl;
        logic [39:0] exp_bits;
        logic [31:0] rx;
        logic [7:0]  b8;
        cpb = use2 ? 2 : 4;
        sel = use2;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0)      exp_bits[i] = 1'b0;
            else if (i % 10 == 9) exp_bits[i] = 1'b1;
            else                  exp_bits[i] = w[24 - 8 * (i / 10) + (i % 10 - 1)];
        end
        seen = '0;
        data_in = w;
        data_valid = 1'b1;
        chk("ready_before_accept", 32'(obs_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) data_valid = 1'b0;
        bad_line = 0;
        bad_ctl = 0;
        for (int j = 1; j <= 40 * cpb; j++) begin
            @(negedge clk);
            if (obs_tx !== exp_bits[(j - 1) / cpb]) bad_line++;
            if ((j - 1) % cpb == 0) seen[(j - 1) / cpb] = obs_tx;
            if (obs_busy !== 1'b1 || obs_ready !== 1'b0 || obs_done !== 1'b0) bad_ctl++;
            if (toggle) begin
                data_valid = ~data_valid;
                data_in = 32'h12345678;
            end
        end
        chk("line_bad_cycles", 32'(bad_line), 32'd0);
        chk("busy_window_bad_cycles", 32'(bad_ctl), 32'd0);
        @(negedge clk);
        if (toggle) data_valid = 1'b0;
        chk("tx_done_at_end", 32'(obs_done), 32'd1);
        chk("busy_at_end", 32'(obs_busy), 32'd0);
        chk("ready_at_end", 32'(obs_ready), 32'd1);
        chk("line_idle_at_end", 32'(obs_tx), 32'd1);
        rx = '0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) b8[k] = seen[10 * f + 1 + k];
            rx = {rx[23:0], b8};
        end
        chk("loopback_word", rx, w);
    endtask

    typedef struct {
        logic [31:0] word;
        bit          use2;
        bit          hold;
        logic [9:0]  frame0;
    } vec_t;

    vec_t        tbl[5];
    logic [39:0] seen;
    logic [9:0]  f0;
    logic [31:0] w;
    bit          hold;
    bit          tog;
    int          bad;

    initial begin
        n_err = 0;
        n_checks = 0;
        sel = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        reset_n = 1'b0;

        // Line sequence written first-bit-leftmost: start, d0..d7, stop.
        tbl[0] = '{32'hA5C30F81, 1'b0, 1'b0, 10'b0101001011};
        tbl[1] = '{32'h01000000, 1'b0, 1'b0, 10'b0100000001};
        tbl[2] = '{32'h80000001, 1'b1, 1'b0, 10'b0000000011};
        tbl[3] = '{32'hFFFFFFFF, 1'b0, 1'b1, 10'b0111111111};
        tbl[4] = '{32'h00000000, 1'b0, 1'b0, 10'b0000000001};

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx1), 32'd1);
        chk("reset_ready", 32'(ready1), 32'd1);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        chk("reset_tx_cpb2", 32'(tx2), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_after_reset", 32'(ready1), 32'd1);

        for (int v = 0; v < 5; v++) begin
            send_word(tbl[v].word, tbl[v].use2, tbl[v].hold, 1'b0, seen);
            for (int k = 0; k < 10; k++) f0[9 - k] = seen[k];
            chk($sformatf("frame0_vec%0d", v), 32'(f0), 32'(tbl[v].frame0));
        end

        // Inputs change while busy: transmitted word must be the accepted one.
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b1, seen);
        send_word(32'h5A3C9617, 1'b1, 1'b0, 1'b1, seen);

        for (int r = 0; r < 6; r++) begin
            w = $urandom;
            hold = (r < 5) && (1'($urandom_range(0, 1)) == 1'b1);
            tog = !hold && (1'($urandom_range(0, 1)) == 1'b1);
            send_word(w, 1'b0, hold, tog, seen);
        end

        // Abort mid-DATA of byte 1; reset acts without a clock edge.
        sel = 1'b0;
        data_in = 32'hDEADBEEF;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("busy_before_abort", 32'(busy1), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_tx_async", 32'(tx1), 32'd1);
        chk("abort_busy_async", 32'(busy1), 32'd0);
        chk("abort_ready_async", 32'(ready1), 32'd1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done1 !== 1'b0) bad++;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done1 !== 1'b0 || tx1 !== 1'b1) bad++;
        end
        chk("no_done_after_abort", 32'(bad), 32'd0);
        send_word(32'h13579BDF, 1'b0, 1'b0, 1'b0, seen);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
